// File: rtl/pipe_pkg.sv
// Shared pipeline types for the ID/EX hazard controller: FSM state, EX shadow flags, $zero.
package pipe_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        MULTI = 1'b1
    } hz_state_e;

    // Flag part of the EX shadow; the destination register is kept beside it so its
    // width can follow the REG_ADDR_W parameter of the instantiating module.
    typedef struct packed {
        logic valid;
        logic mem_read;
        logic multicycle;
    } ex_shadow_t;

    localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/hazard_perf_cnt.sv
// 16-bit saturating event counter with asynchronous active-low reset.
module hazard_perf_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    output logic [15:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != 16'hFFFF)) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/hazard_ctrl_id_ex.sv
// ID/EX hazard controller: load-use, taken branch, mul/div and data-memory stalls.
// Optional HAZARD_PERF_EN adds saturating stall/flush counters.
module hazard_ctrl_id_ex
    import pipe_pkg::*;
#(
    parameter int unsigned REG_ADDR_W    = 5,
    parameter int unsigned MULDIV_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  id_mem_read,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_multicycle,
    input  logic                  ex_branch_taken,
    input  logic                  mem_stall,
    output logic                  pc_we,
    output logic                  if_id_we,
    output logic                  id_ex_we,
    output logic                  id_ex_bubble,
    output logic                  if_id_flush,
    output logic                  busy
`ifdef HAZARD_PERF_EN
    ,
    output logic [15:0]           perf_stall_cycles,
    output logic [15:0]           perf_flushes
`endif
);

    localparam int unsigned CNT_W = (MULDIV_CYCLES > 2) ? $clog2(MULDIV_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 2);

    hz_state_e             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    ex_shadow_t            ex_q;
    logic [REG_ADDR_W-1:0] ex_dest_q;
    logic                  load_use;

    assign load_use = ex_q.valid && ex_q.mem_read &&
                      (ex_dest_q != REG_ADDR_W'(REG_ZERO)) &&
                      ((id_uses_rs && (id_rs == ex_dest_q)) ||
                       (id_uses_rt && (id_rt == ex_dest_q)));

    assign busy = (state_q == MULTI);

    always_comb begin
        pc_we        = 1'b1;
        if_id_we     = 1'b1;
        id_ex_we     = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        state_d      = state_q;
        cnt_d        = cnt_q;
        if (!rst_n) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_we     = 1'b0;
            id_ex_bubble = 1'b1;
            if_id_flush  = 1'b1;
        end else if (mem_stall) begin
            pc_we    = 1'b0;
            if_id_we = 1'b0;
            id_ex_we = 1'b0;
        end else if ((state_q == MULTI) && (cnt_q != '0)) begin
            // mul/div still occupies EX; a branch cannot be resolving here
            pc_we    = 1'b0;
            if_id_we = 1'b0;
            id_ex_we = 1'b0;
            cnt_d    = cnt_q - CNT_W'(1);
        end else begin
            if (state_q == MULTI) begin
                state_d = IDLE;
            end
            if (ex_branch_taken) begin
                id_ex_bubble = 1'b1;
                if_id_flush  = 1'b1;
            end else if ((state_q == IDLE) && ex_q.valid && ex_q.multicycle) begin
                pc_we    = 1'b0;
                if_id_we = 1'b0;
                id_ex_we = 1'b0;
                state_d  = MULTI;
                cnt_d    = CNT_LOAD;
            end else if (load_use) begin
                pc_we        = 1'b0;
                if_id_we     = 1'b0;
                id_ex_bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q      <= '0;
            ex_dest_q <= '0;
        end else if (id_ex_we) begin
            ex_q.valid      <= id_valid & ~id_ex_bubble;
            ex_q.mem_read   <= id_mem_read;
            ex_q.multicycle <= id_multicycle;
            ex_dest_q       <= id_dest;
        end
    end

`ifdef HAZARD_PERF_EN
    hazard_perf_cnt u_perf_stall (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (rst_n & ~pc_we),
        .count (perf_stall_cycles)
    );

    hazard_perf_cnt u_perf_flush (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (rst_n & if_id_flush),
        .count (perf_flushes)
    );
`endif

endmodule

// File: tb/tb_hazard_ctrl_id_ex.sv
// Directed bench for hazard_ctrl_id_ex with an expected-output scoreboard queue.
module tb_hazard_ctrl_id_ex;

    localparam int unsigned AW = 5;

    // {pc_we, if_id_we, id_ex_we, id_ex_bubble, if_id_flush, busy}
    localparam logic [5:0] E_NORM  = 6'b111_000;
    localparam logic [5:0] E_STALL = 6'b000_000;
    localparam logic [5:0] E_BUSY  = 6'b000_001;
    localparam logic [5:0] E_LU    = 6'b001_100;
    localparam logic [5:0] E_BR    = 6'b111_110;
    localparam logic [5:0] E_RST   = 6'b000_110;
    localparam logic [5:0] E_REL   = 6'b111_001;

    typedef struct {
        string      tag;
        logic [5:0] v;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid, id_uses_rs, id_uses_rt, id_mem_read, id_multicycle;
    logic [AW-1:0] id_rs, id_rt, id_dest;
    logic          ex_branch_taken, mem_stall;
    logic          pc_we, if_id_we, id_ex_we, id_ex_bubble, if_id_flush, busy;
`ifdef HAZARD_PERF_EN
    logic [15:0]   perf_stall_cycles, perf_flushes;
`endif

    exp_t          sb[$];
    int            n_tests = 0;
    int            n_fail  = 0;

    hazard_ctrl_id_ex #(
        .REG_ADDR_W    (AW),
        .MULDIV_CYCLES (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .id_mem_read     (id_mem_read),
        .id_dest         (id_dest),
        .id_multicycle   (id_multicycle),
        .ex_branch_taken (ex_branch_taken),
        .mem_stall       (mem_stall),
        .pc_we           (pc_we),
        .if_id_we        (if_id_we),
        .id_ex_we        (id_ex_we),
        .id_ex_bubble    (id_ex_bubble),
        .if_id_flush     (if_id_flush),
        .busy            (busy)
`ifdef HAZARD_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flushes      (perf_flushes)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic set_id(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                          input logic urs, input logic urt, input logic mr,
                          input logic [AW-1:0] dest, input logic mc);
        id_valid      = v;
        id_rs         = rs;
        id_rt         = rt;
        id_uses_rs    = urs;
        id_uses_rt    = urt;
        id_mem_read   = mr;
        id_dest       = dest;
        id_multicycle = mc;
    endtask

    // Push the expectation, compare at the falling edge, then advance past the next rising edge.
    task automatic cyc(input string tag, input logic [5:0] v);
        exp_t e;
        exp_t got;
        logic [5:0] obs;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
        @(negedge clk);
        got = sb.pop_front();
        obs = {pc_we, if_id_we, id_ex_we, id_ex_bubble, if_id_flush, busy};
        n_tests++;
        assert (obs === got.v) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", got.tag, obs, got.v);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_perf(input string tag, input logic [15:0] exp_stall);
`ifdef HAZARD_PERF_EN
        n_tests++;
        assert (perf_stall_cycles === exp_stall) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, perf_stall_cycles, exp_stall);
        end
`else
        if (tag.len() == 0 && exp_stall != 16'd0) $display("unused");
`endif
    endtask

    initial begin
        rst_n           = 1'b0;
        ex_branch_taken = 1'b0;
        mem_stall       = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);

        cyc("reset_outputs", E_RST);
        rst_n = 1'b1;

        cyc("idle_nop", E_NORM);
        chk_perf("perf_after_reset", 16'd0);

        // Load-use on rs
        set_id(1, 1, 2, 0, 0, 1, 5, 0);
        cyc("ld5_issue", E_NORM);
        set_id(1, 5, 3, 1, 0, 0, 6, 0);
        cyc("lu_stall", E_LU);
        cyc("lu_resume", E_NORM);

        // $0 never hazards
        set_id(1, 1, 2, 0, 0, 1, 0, 0);
        cyc("ld0_issue", E_NORM);
        set_id(1, 0, 0, 1, 1, 0, 6, 0);
        cyc("zero_filter", E_NORM);

        // Matching register that is not actually read
        set_id(1, 1, 2, 0, 0, 1, 8, 0);
        cyc("ld8_issue", E_NORM);
        set_id(1, 8, 8, 0, 0, 0, 6, 0);
        cyc("no_use", E_NORM);

        // Branch beats load-use (match on rt)
        set_id(1, 1, 2, 0, 0, 1, 7, 0);
        cyc("ld7_issue", E_NORM);
        set_id(1, 3, 7, 0, 1, 0, 6, 0);
        ex_branch_taken = 1'b1;
        cyc("br_prio", E_BR);
        ex_branch_taken = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        cyc("br_after", E_NORM);

        // Plain multicycle: 3 stall cycles then release
        set_id(1, 1, 2, 1, 1, 0, 9, 1);
        cyc("mul_issue", E_NORM);
        set_id(1, 3, 4, 1, 1, 0, 10, 0);
        cyc("mul_s1", E_STALL);
        cyc("mul_s2", E_BUSY);
        cyc("mul_s3", E_BUSY);
        cyc("mul_rel", E_REL);
        cyc("mul_done", E_NORM);

        // mem_stall while cnt=1 freezes the counter; branch ignored in stall
        set_id(1, 1, 2, 1, 1, 0, 9, 1);
        cyc("mul2_issue", E_NORM);
        set_id(1, 3, 4, 1, 1, 0, 10, 0);
        cyc("mul2_s1", E_STALL);
        cyc("mul2_s2", E_BUSY);
        mem_stall = 1'b1;
        cyc("ms_1", E_BUSY);
        cyc("ms_2", E_BUSY);
        mem_stall       = 1'b0;
        ex_branch_taken = 1'b1;
        cyc("mul2_s3_br_ign", E_BUSY);
        ex_branch_taken = 1'b0;
        cyc("mul2_rel", E_REL);
        cyc("mul2_done", E_NORM);

        // mem_stall in plain IDLE
        mem_stall = 1'b1;
        cyc("ms_idle", E_STALL);
        mem_stall = 1'b0;

        // Reset mid-MULTI aborts
        set_id(1, 1, 2, 1, 1, 0, 9, 1);
        cyc("mul3_issue", E_NORM);
        set_id(1, 3, 4, 1, 1, 0, 10, 0);
        cyc("mul3_s1", E_STALL);
        cyc("mul3_s2", E_BUSY);
        rst_n = 1'b0;
        cyc("rst_mid", E_RST);
        chk_perf("perf_in_reset", 16'd0);
        rst_n = 1'b1;
        cyc("rst_after", E_NORM);
        chk_perf("perf_after_rst", 16'd0);
        cyc("rst_after2", E_NORM);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_id_ex.md
# hazard_ctrl_id_ex

Pipeline hazard controller for the ID/EX stage of the 5-stage MIPS core. Every cycle it decides whether PC, IF/ID and ID/EX load, hold, or take a bubble or flush. It covers load-use hazards, taken-branch flushes, multicycle EX operations (mul/div) and data-memory stalls. It keeps a shadow copy of the hazard-relevant fields of the instruction currently in EX.

## Interface
- `REG_ADDR_W`, 5: register-address width.
- `MULDIV_CYCLES`, 4: total cycles a multicycle op occupies EX; must be ≥2.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_valid` in 1: ID holds a real instruction.
- `id_rs`, `id_rt` in REG_ADDR_W: source registers of the ID instruction.
- `id_uses_rs`, `id_uses_rt` in 1: the matching source register is actually read.
- `id_mem_read` in 1: the ID instruction is a load.
- `id_dest` in REG_ADDR_W: destination register of the ID instruction.
- `id_multicycle` in 1: the ID instruction is a mul/div.
- `ex_branch_taken` in 1: a branch resolved taken in EX this cycle.
- `mem_stall` in 1: data memory not ready; freeze the whole front end.
- `pc_we`, `if_id_we`, `id_ex_we` out 1: register load enables.
- `id_ex_bubble` out 1: ID/EX loads a NOP (all control zero) instead of the ID contents.
- `if_id_flush` out 1: IF/ID loads a NOP.
- `busy` out 1: FSM is in MULTI.

## Operation
- **Shadow EX register:** `ex_valid`, `ex_mem_read`, `ex_dest`, `ex_multicycle`.
  - On a clock edge with `id_ex_we=1`, it captures the ID fields.
  - `ex_valid <= id_valid & ~id_ex_bubble`.
  - With `id_ex_we=0`, it holds.
- **FSM states:** IDLE and MULTI, plus a down-counter `cnt` of width `$clog2(MULDIV_CYCLES)`.
- **Decisions, highest priority first:**
  1. **mem_stall:** all three enables 0, bubble 0, flush 0. FSM, `cnt` and shadow register hold.
  2. **MULTI with `cnt≠0`:** all enables 0. `cnt` decrements.
  3. **MULTI with `cnt=0`:** release with normal enables, then go to IDLE. Rules 4–6 also apply in this cycle.
  4. **ex_branch_taken:** `if_id_flush=1` and `id_ex_bubble=1`, with all enables 1.
  5. **IDLE with `ex_valid & ex_multicycle`:** all enables 0. Next state is MULTI with `cnt=MULDIV_CYCLES-2`.
  6. **Load-use:** condition is `ex_valid & ex_mem_read & ex_dest≠0 & ((id_uses_rs & id_rs==ex_dest) | (id_uses_rt & id_rt==ex_dest))`. Then `pc_we=0`, `if_id_we=0`, `id_ex_we=1`, `id_ex_bubble=1`.
  7. **Otherwise:** all enables 1, bubble 0, flush 0.
- **Ignored inputs:** `ex_branch_taken` is ignored during MULTI stall cycles, because a mul/div in EX is never a branch. Register 0 never causes a hazard.

## Timing
- Outputs are combinational (Mealy) from the inputs and the registered state. State updates on the rising edge of `clk`.
- Load-use costs exactly 1 bubble cycle. A taken branch costs 2 slots (IF/ID and ID/EX). A mul/div stays in EX for exactly MULDIV_CYCLES cycles (MULDIV_CYCLES−1 stall cycles), plus any cycles where `mem_stall` is high.
- **While `rst_n=0`:**
  - FSM is IDLE, `cnt=0`, shadow register all 0.
  - Outputs forced: `pc_we=if_id_we=id_ex_we=0`, `id_ex_bubble=1`, `if_id_flush=1`, `busy=0`.
- Reset asserted mid-MULTI aborts the operation. After release the block is in IDLE with no pending stall.

## Configuration
- **`HAZARD_PERF_EN` defined:** adds two 16-bit saturating outputs.
  - `perf_stall_cycles` counts cycles with `pc_we=0` and `rst_n=1`.
  - `perf_flushes` counts cycles with `if_id_flush=1` and `rst_n=1`.
  - Both reset to 0 and stick at 16'hFFFF.
- **Not defined:** these ports and their counters do not exist. All other behaviour is identical.

## Structure
- **Shared package `pipe_pkg`:**
  - FSM state typedef (IDLE, MULTI).
  - Shadow-EX struct typedef.
  - `REG_ZERO` constant.
- **Sub-module `hazard_perf_cnt`:** one 16-bit saturating counter, instantiated twice under `HAZARD_PERF_EN`. Everything else stays flat.

## Test plan
- **Load-use:** load writing $5 issued, next instruction reads rs=$5 → exactly one cycle with `pc_we=0`, `if_id_we=0`, `id_ex_bubble=1`. Next cycle: all enables 1.
- **$0 filter:** load writing $0, next instruction reads rs=$0 → no stall.
- **Branch priority:** `ex_branch_taken=1` in the same cycle as a load-use match → `if_id_flush=1`, `id_ex_bubble=1`, `pc_we=1`.
- **Multicycle:** MULDIV_CYCLES=4, mul issued → 3 cycles with all enables 0, `busy=1` on cycles 2–3. 4th cycle: release, IDLE.
- **mem_stall mid-MULTI:** `mem_stall` for 2 cycles during MULTI with `cnt=1` → `cnt` holds, total stall is 5 cycles.
- **Reset mid-MULTI:** `rst_n` low for 1 cycle mid-MULTI → enables 0 and bubble/flush 1 while low. After release: `busy=0`, all enables 1. With `HAZARD_PERF_EN`, `perf_stall_cycles` reads 0.
